sub_bytes_seq: RTL and testbench

- Sequential forward SubBytes engine for the encrypt datapath. It is the forward counterpart of the decrypt-side inverse byte substitution.
- Accepts a 128-bit AES state over a valid/ready handshake and substitutes BPC bytes per cycle through BPC copies of the forward Rijndael S-box.
- Returns the substituted 128-bit state over a second valid/ready handshake.
- Sits between AddRoundKey and ShiftRows in the iterative encrypt round.

---
 rtl/aes_pkg.sv | 27 ++
 rtl/sbox_fwd.sv | 41 ++++
 rtl/sub_bytes_seq.sv | 114 +++++++++++
 tb/tb_sub_bytes_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Brief    : Shared AES types, state-machine encoding and byte-index helper
//            for the encrypt round datapath.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int AES_BYTES = 16;

  typedef logic [7:0]             aes_byte_t;
  typedef logic [8*AES_BYTES-1:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // Byte 0 is the most significant byte of the state word.
  function automatic int byte_msb(input int i);
    return 8*AES_BYTES - 1 - 8*i;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sbox_fwd.sv
`default_nettype none
// ============================================================================
// Module   : sbox_fwd
// Brief    : Combinational forward Rijndael S-box (FIPS-197 table), one byte.
// Revision : 1.0 - initial release
// ============================================================================
module sbox_fwd (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  logic [127:0] w_row;

  // Select the table row by high nibble; the low nibble picks the column.
  always_comb begin
    w_row = '0;
    case (i_byte[7:4])
      4'h0: w_row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: w_row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: w_row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: w_row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: w_row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: w_row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: w_row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: w_row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: w_row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: w_row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: w_row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: w_row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: w_row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: w_row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: w_row = 128'he1f8981169d98e949b1e87e9ce5528df;
      4'hf: w_row = 128'h8ca1890dbfe6426841992d0fb054bb16;
      default: w_row = '0;
    endcase
  end

  assign o_byte = w_row[127 - 8*int'(i_byte[3:0]) -: 8];

endmodule
`default_nettype wire

// File: rtl/sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module   : sub_bytes_seq
// Brief    : Sequential forward SubBytes engine. Accepts a 128-bit state,
//            substitutes BPC bytes per cycle (byte 0 first) and returns the
//            result over a valid/ready handshake. No overlap between blocks.
// Revision : 1.0 - initial release
// ============================================================================
module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int BPC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NSTEP = AES_BYTES / BPC;
  localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  fsm_t           r_state;
  logic [SW-1:0]  r_step;
  aes_state_t     r_work;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_busy;

  aes_byte_t      w_sb_in  [BPC];
  aes_byte_t      w_sb_out [BPC];

  // One S-box per lane; lane j looks at byte step*BPC+j of the working register.
  for (genvar j = 0; j < BPC; j++) begin : g_sbox
    assign w_sb_in[j] = r_work[byte_msb(int'(r_step)*BPC + j) -: 8];

    sbox_fwd u_sbox (
      .i_byte (w_sb_in[j]),
      .o_byte (w_sb_out[j])
    );
  end

  // Control FSM and working register; handshake outputs are registered and
  // in_ready is held low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_step      <= '0;
      r_work      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (flush) begin
      // Abort wins over every transition; the working register keeps its value.
      r_state     <= IDLE;
      r_step      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_work     <= in_state;
            r_step     <= '0;
            r_state    <= BUSY;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        BUSY: begin
          for (int j = 0; j < BPC; j++) begin
            r_work[byte_msb(int'(r_step)*BPC + j) -: 8] <= w_sb_out[j];
          end
          if (r_step == SW'(NSTEP - 1)) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_step <= r_step + SW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_step      <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_state = r_work;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_bytes_seq
// Brief    : Self-checking bench for sub_bytes_seq (BPC=4 main instance plus
//            BPC=1 and BPC=16 instances). Reference S-box is computed from
//            GF(2^8) inversion and the affine map.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst_n;

  // Main instance (BPC=4)
  logic         flush, in_valid, out_ready;
  logic [127:0] in_state;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_state;

  // Sweep instances share their inputs
  logic         sw_flush, sw_in_valid, sw_out_ready;
  logic [127:0] sw_in_state;
  logic         a_in_ready, a_out_valid, a_busy;
  logic [127:0] a_out_state;
  logic         b_in_ready, b_out_valid, b_busy;
  logic [127:0] b_out_state;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [127:0] sb_q[$];
  logic [7:0]   m_fwd [256];
  logic [7:0]   m_inv [256];
  logic [127:0] C1_IN  = 128'h00112233445566778899aabbccddeeff;
  logic [127:0] C1_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;

  always #5 clk = ~clk;

  sub_bytes_seq #(.BPC(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_state(in_state), .out_valid(out_valid),
    .out_ready(out_ready), .out_state(out_state), .busy(busy)
  );

  sub_bytes_seq #(.BPC(1)) u_dut_bpc1 (
    .clk(clk), .rst_n(rst_n), .flush(sw_flush), .in_valid(sw_in_valid),
    .in_ready(a_in_ready), .in_state(sw_in_state), .out_valid(a_out_valid),
    .out_ready(sw_out_ready), .out_state(a_out_state), .busy(a_busy)
  );

  sub_bytes_seq #(.BPC(16)) u_dut_bpc16 (
    .clk(clk), .rst_n(rst_n), .flush(sw_flush), .in_valid(sw_in_valid),
    .in_ready(b_in_ready), .in_state(sw_in_state), .out_valid(b_out_valid),
    .out_ready(sw_out_ready), .out_state(b_out_state), .busy(b_busy)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_model();
    logic [7:0] iv, s;
    for (int x = 0; x < 256; x++) begin
      iv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      s = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]}
             ^ {iv[3:0], iv[7:4]} ^ 8'h63;
      m_fwd[x] = s;
      m_inv[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] sub_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = m_fwd[s[127-8*i -: 8]];
    return r;
  endfunction

  // Sends one block with out_ready=1 and checks the result against the
  // scoreboard. lat = edges from input handshake to out_valid visible.
  task automatic run_block(input logic [127:0] st, output int lat, output logic [127:0] got);
    logic [127:0] exp_s;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL in_ready_before_send: got %b need 1", in_ready); end
    in_valid = 1'b1; in_state = st; out_ready = 1'b1;
    sb_q.push_back(sub_state(st));
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_after_accept: got %b need 1", busy); end
    while (!out_valid && lat < 64) begin @(negedge clk); lat++; end
    got = out_state;
    exp_s = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
    n_cmp++;
    if (out_valid !== 1'b1 || got !== exp_s) begin
      n_bad++; $display("FAIL block_result: valid %b got %h expected %h", out_valid, got, exp_s);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL return_to_idle: valid %b ready %b busy %b need 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    flush = 0; in_valid = 0; out_ready = 0; in_state = '0;
    sw_flush = 0; sw_in_valid = 0; sw_out_ready = 0; sw_in_state = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b000 || out_state !== '0) begin
      n_bad++; $display("FAIL reset_state: rdy/vld/busy %b state %h need 000 / 0", {in_ready, out_valid, busy}, out_state);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset: ready %b busy %b need 1/0", in_ready, busy);
    end
  endtask

  task automatic test_c1();
    int lat; logic [127:0] got;
    run_block(C1_IN, lat, got);
    n_cmp++;
    if (lat !== 4) begin n_bad++; $display("FAIL c1_latency: got %0d need 4", lat); end
    n_cmp++;
    if (got !== C1_OUT) begin n_bad++; $display("FAIL c1_vector: got %h need %h", got, C1_OUT); end
    // in_ready was high the cycle after the output handshake, so the next
    // block can be accepted on the second edge after out_valid rose.
  endtask

  task automatic test_exhaustive();
    int lat; logic [127:0] st, got; logic [7:0] b;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) st[127-8*i -: 8] = 8'(16*k + i);
      run_block(st, lat, got);
      for (int i = 0; i < 16; i++) begin
        b = got[127-8*i -: 8];
        n_cmp++;
        if (b !== m_fwd[16*k+i]) begin n_bad++; $display("FAIL sbox_%02h: got %h need %h", 16*k+i, b, m_fwd[16*k+i]); end
        n_cmp++;
        if (m_inv[b] !== 8'(16*k+i)) begin n_bad++; $display("FAIL inverse_%02h: got %h need %h", 16*k+i, m_inv[b], 8'(16*k+i)); end
      end
      if (k == 5) begin
        n_cmp++;
        if (got[127-8*2 -: 8] !== 8'h00) begin n_bad++; $display("FAIL spot_S52: got %h need 00", got[127-8*2 -: 8]); end
        n_cmp++;
        if (got[127-8*3 -: 8] !== 8'hed) begin n_bad++; $display("FAIL spot_S53: got %h need ed", got[127-8*3 -: 8]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] st, cap, exp_s; int n;
    st = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    in_valid = 1'b1; in_state = st; out_ready = 1'b0;
    sb_q.push_back(sub_state(st));
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 64) begin @(negedge clk); n++; end
    cap = out_state;
    in_valid = 1'b1; in_state = ~st;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_state !== cap || in_ready !== 1'b0 || busy !== 1'b1) begin
        n_bad++; $display("FAIL bp_hold_%0d: vld %b rdy %b busy %b state %h need 1/0/1 %h", c, out_valid, in_ready, busy, out_state, cap);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    exp_s = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
    n_cmp++;
    if (cap !== exp_s) begin n_bad++; $display("FAIL bp_result: got %h need %h", cap, exp_s); end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL bp_release: vld %b rdy %b busy %b need 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_flush();
    int lat, seen; logic [127:0] got;
    @(negedge clk);
    in_valid = 1'b1; in_state = 128'h0123456789abcdef0123456789abcdef; out_ready = 1'b1;
    @(negedge clk);               // accepted, step 0
    in_valid = 1'b0;
    @(negedge clk);               // step 1
    @(negedge clk);               // step 2
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL flush_busy: vld %b busy %b rdy %b need 0/0/1", out_valid, busy, in_ready);
    end
    seen = 0;
    repeat (6) begin @(negedge clk); if (out_valid) seen++; end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL flush_no_output: got %0d valid cycles need 0", seen); end
    // in_valid together with flush must not start a block
    flush = 1'b1; in_valid = 1'b1; in_state = '1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL flush_blocks_accept: busy %b rdy %b need 0/1", busy, in_ready);
    end
    run_block('0, lat, got);
    n_cmp++;
    if (got !== {16{8'h63}}) begin n_bad++; $display("FAIL flush_next_block: got %h need all 63", got); end
  endtask

  task automatic test_async_reset();
    int lat; logic [127:0] got;
    @(negedge clk);
    in_valid = 1'b1; in_state = C1_IN; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);               // mid-BUSY
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_state !== '0) begin
      n_bad++; $display("FAIL async_reset: vld %b busy %b rdy %b state %h need 0/0/0 0", out_valid, busy, in_ready, out_state);
    end
    #1 rst_n = 1'b1;
    @(posedge clk);
    run_block(C1_IN, lat, got);
    n_cmp++;
    if (got !== C1_OUT || lat !== 4) begin
      n_bad++; $display("FAIL post_reset_block: got %h lat %0d need %h lat 4", got, lat, C1_OUT);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] sts [3];
    logic [127:0] exp_s;
    int acc_cyc [3];
    int idx, nout, cyc;
    logic pend;
    for (int i = 0; i < 3; i++) sts[i] = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_state = sts[0];
    idx = 0; nout = 0; cyc = 0; pend = 1'b0;
    while (nout < 3 && cyc < 100) begin
      if (pend) begin
        sb_q.push_back(sub_state(in_state));
        acc_cyc[idx] = cyc;
        idx++;
        pend = 1'b0;
        if (idx < 3) in_state = sts[idx]; else in_valid = 1'b0;
      end
      if (in_valid && in_ready) pend = 1'b1;
      if (out_valid && out_ready) begin
        exp_s = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
        n_cmp++;
        if (out_state !== exp_s) begin n_bad++; $display("FAIL b2b_result_%0d: got %h need %h", nout, out_state, exp_s); end
        nout++;
      end
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (nout !== 3) begin n_bad++; $display("FAIL b2b_count: got %0d need 3", nout); end
    for (int i = 1; i < 3; i++) begin
      n_cmp++;
      if (idx > i && acc_cyc[i] - acc_cyc[i-1] !== 6) begin
        n_bad++; $display("FAIL b2b_period_%0d: got %0d need 6", i, acc_cyc[i] - acc_cyc[i-1]);
      end else if (idx <= i) begin
        n_bad++; $display("FAIL b2b_period_%0d: block not accepted need 6", i);
      end
    end
  endtask

  task automatic test_sweep();
    int n, lat_a, lat_b;
    logic [127:0] got_a, got_b;
    @(negedge clk);
    n_cmp++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      n_bad++; $display("FAIL sweep_ready: bpc1 %b bpc16 %b need 1/1", a_in_ready, b_in_ready);
    end
    sw_in_valid = 1'b1; sw_in_state = C1_IN; sw_out_ready = 1'b1;
    @(negedge clk);
    sw_in_valid = 1'b0;
    n = 0; lat_a = -1; lat_b = -1; got_a = '0; got_b = '0;
    while (n < 40 && (lat_a < 0 || lat_b < 0)) begin
      if (a_out_valid && lat_a < 0) begin lat_a = n; got_a = a_out_state; end
      if (b_out_valid && lat_b < 0) begin lat_b = n; got_b = b_out_state; end
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (lat_a !== 16) begin n_bad++; $display("FAIL bpc1_latency: got %0d need 16", lat_a); end
    n_cmp++;
    if (lat_b !== 1) begin n_bad++; $display("FAIL bpc16_latency: got %0d need 1", lat_b); end
    n_cmp++;
    if (got_a !== C1_OUT) begin n_bad++; $display("FAIL bpc1_vector: got %h need %h", got_a, C1_OUT); end
    n_cmp++;
    if (got_b !== C1_OUT) begin n_bad++; $display("FAIL bpc16_vector: got %h need %h", got_b, C1_OUT); end
  endtask

  initial begin
    build_model();
    test_reset();
    test_c1();
    test_exhaustive();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
